// File: rtl/pcs_rx_block_lock_pkg.sv
// Shared PCS receive definitions: sync-header codes, block-lock FSM states
// and the default lock/unlock thresholds.
package pcs_rx_block_lock_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int unsigned LOCK_COUNT_DEF    = 64;
  localparam int unsigned INVALID_LIMIT_DEF = 16;

  typedef enum logic [1:0] {
    RESET_CNT = 2'd0,
    TEST_SH   = 2'd1,
    SLIP      = 2'd2
  } lock_state_e;

  // A sync header is valid only when its two bits differ.
  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/pcs_rx_block_lock.sv
// Block-lock controller for the 10G PCS receive path.
// Watches the sync header of each 66-bit block, commands gearbox bit-slips
// until alignment is found, then holds lock until too many headers go bad.
//
// Ports:
//   clk             PCS RX clock
//   rst             asynchronous active-low reset
//   in_header       sync header of the current block
//   in_header_valid in_header qualified this cycle
//   in_data_valid   payload valid from the gearbox
//   out_block_lock  block alignment acquired (registered)
//   out_slip        one-cycle bit-slip request to the gearbox (registered)
//   out_data_valid  in_data_valid gated by lock (combinational)
//   out_sh_invalid  previous qualified header was invalid (registered)
module pcs_rx_block_lock
  import pcs_rx_block_lock_pkg::*;
#(
  parameter int unsigned LOCK_COUNT    = LOCK_COUNT_DEF,
  parameter int unsigned INVALID_LIMIT = INVALID_LIMIT_DEF,
  parameter int unsigned SLIP_WAIT     = 4,
  parameter int unsigned CNT_WIDTH     = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in_header,
  input  logic       in_header_valid,
  input  logic       in_data_valid,
  output logic       out_block_lock,
  output logic       out_slip,
  output logic       out_data_valid,
  output logic       out_sh_invalid
);

  lock_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] sh_cnt_q, sh_cnt_d;
  logic [CNT_WIDTH-1:0] inv_cnt_q, inv_cnt_d;
  logic [CNT_WIDTH-1:0] slip_timer_q, slip_timer_d;
  logic                 lock_d, slip_d, sh_inv_d;
  logic                 hdr_bad;
  logic [CNT_WIDTH-1:0] sh_inc, inv_inc;

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RESET_CNT;
      sh_cnt_q       <= '0;
      inv_cnt_q      <= '0;
      slip_timer_q   <= '0;
      out_block_lock <= 1'b0;
      out_slip       <= 1'b0;
      out_sh_invalid <= 1'b0;
    end else begin
      state_q        <= state_d;
      sh_cnt_q       <= sh_cnt_d;
      inv_cnt_q      <= inv_cnt_d;
      slip_timer_q   <= slip_timer_d;
      out_block_lock <= lock_d;
      out_slip       <= slip_d;
      out_sh_invalid <= sh_inv_d;
    end
  end

  // Next-state, counter and output logic.
  always_comb begin
    state_d      = state_q;
    sh_cnt_d     = sh_cnt_q;
    inv_cnt_d    = inv_cnt_q;
    slip_timer_d = slip_timer_q;
    lock_d       = out_block_lock;
    slip_d       = 1'b0;
    sh_inv_d     = 1'b0;
    hdr_bad      = !sh_is_valid(in_header);
    sh_inc       = sh_cnt_q + CNT_WIDTH'(1);
    inv_inc      = inv_cnt_q + CNT_WIDTH'(hdr_bad);

    case (state_q)
      RESET_CNT: begin
        sh_cnt_d  = '0;
        inv_cnt_d = '0;
        state_d   = TEST_SH;
      end

      TEST_SH: begin
        if (in_header_valid) begin
          sh_cnt_d  = sh_inc;
          inv_cnt_d = inv_inc;
          sh_inv_d  = hdr_bad;
          // Rule order matters: an invalid-limit hit beats window completion.
          if (hdr_bad && !out_block_lock) begin
            state_d      = SLIP;
            slip_d       = 1'b1;
            slip_timer_d = '0;
          end else if (hdr_bad && (inv_inc == CNT_WIDTH'(INVALID_LIMIT))) begin
            lock_d       = 1'b0;
            state_d      = SLIP;
            slip_d       = 1'b1;
            slip_timer_d = '0;
          end else if (sh_inc == CNT_WIDTH'(LOCK_COUNT)) begin
            if (inv_inc == '0) begin
              lock_d = 1'b1;
            end
            state_d = RESET_CNT;
          end
        end
      end

      SLIP: begin
        // The entry cycle counts as the first of the SLIP_WAIT settle cycles.
        lock_d       = 1'b0;
        slip_timer_d = slip_timer_q + CNT_WIDTH'(1);
        if (slip_timer_q == CNT_WIDTH'(SLIP_WAIT - 1)) begin
          state_d = RESET_CNT;
        end
      end

      default: begin
        state_d = RESET_CNT;
      end
    endcase
  end

  assign out_data_valid = in_data_valid & out_block_lock;

endmodule

// File: tb/tb_pcs_rx_block_lock.sv
// Directed bench for pcs_rx_block_lock: each step drives one cycle of input,
// queues the outputs expected one edge later, then pops and compares them.
module tb_pcs_rx_block_lock;

  logic       clk;
  logic       rst;
  logic [1:0] in_header;
  logic       in_header_valid;
  logic       in_data_valid;
  logic       out_block_lock;
  logic       out_slip;
  logic       out_data_valid;
  logic       out_sh_invalid;

  int checks;
  int errors;

  typedef struct packed {
    logic lock;
    logic slip;
    logic inv;
    logic dv;
  } exp_t;

  exp_t exp_q[$];

  pcs_rx_block_lock dut (
    .clk             (clk),
    .rst             (rst),
    .in_header       (in_header),
    .in_header_valid (in_header_valid),
    .in_data_valid   (in_data_valid),
    .out_block_lock  (out_block_lock),
    .out_slip        (out_slip),
    .out_data_valid  (out_data_valid),
    .out_sh_invalid  (out_sh_invalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Drive one cycle, queue the expectation, compare just after the edge.
  task automatic step(input logic [1:0] h, input logic hv, input logic dv,
                      input logic el, input logic es, input logic ei);
    exp_t e;
    in_header       = h;
    in_header_valid = hv;
    in_data_valid   = dv;
    exp_q.push_back('{lock: el, slip: es, inv: ei, dv: dv & el});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("block_lock", out_block_lock, e.lock);
    chk("slip", out_slip, e.slip);
    chk("sh_invalid", out_sh_invalid, e.inv);
    chk("data_valid", out_data_valid, e.dv);
  endtask

  // Settle through SLIP (headers ignored) and the one RESET_CNT cycle.
  task automatic recover_from_slip();
    for (int i = 0; i < 4; i++) step(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0] good;
    logic [1:0] bad;
    logic       dv;
    logic       is_bad;
    checks = 0;
    errors = 0;
    rst             = 1'b0;
    in_header       = 2'b00;
    in_header_valid = 1'b0;
    in_data_valid   = 1'b1;

    // Reset state.
    @(posedge clk);
    #1;
    chk("rst_lock", out_block_lock, 1'b0);
    chk("rst_slip", out_slip, 1'b0);
    chk("rst_sh_invalid", out_sh_invalid, 1'b0);
    chk("rst_data_valid", out_data_valid, 1'b0);
    rst = 1'b1;

    // RESET_CNT cycle, then an invalid first header forces a slip.
    step(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    recover_from_slip();

    // 64 clean headers declare lock on the 64th.
    for (int i = 0; i < 64; i++) begin
      good = (i % 2 == 0) ? 2'b01 : 2'b10;
      step(good, 1'b1, 1'b1, (i == 63), 1'b0, 1'b0);
    end

    // Locked: RESET_CNT ignores a bad header, then a window with 15 invalid
    // headers and some unqualified gaps keeps lock.
    step(2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      if (i % 8 == 7) step(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      is_bad = (i % 4 == 0) && (i < 60);
      bad    = (i % 8 == 0) ? 2'b00 : 2'b11;
      good   = (i % 2 == 0) ? 2'b10 : 2'b01;
      dv     = 1'($urandom_range(0, 1));
      step(is_bad ? bad : good, 1'b1, dv, 1'b1, 1'b0, is_bad);
    end

    // 16th invalid lands on the 64th header: unlock and slip win.
    step(2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      is_bad = (i >= 33) && (i % 2 == 1);
      step(is_bad ? 2'b11 : 2'b01, 1'b1, 1'b1, (i != 63), (i == 63), is_bad);
    end
    recover_from_slip();

    // 63 valid then one invalid: no lock, immediate slip; then lock again.
    for (int i = 0; i < 63; i++) step(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    recover_from_slip();
    for (int i = 0; i < 64; i++) step(2'b10, 1'b1, 1'b1, (i == 63), 1'b0, 1'b0);

    // Locked with toggling data valid, then asynchronous reset mid-cycle.
    for (int i = 0; i < 6; i++) step(2'b01, 1'b1, (i % 2 == 0), 1'b1, 1'b0, 1'b0);
    in_data_valid = 1'b1;
    #1;
    chk("pre_rst_data_valid", out_data_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk("async_rst_lock", out_block_lock, 1'b0);
    chk("async_rst_data_valid", out_data_valid, 1'b0);
    chk("async_rst_slip", out_slip, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset while out_slip is high clears it immediately.
    step(2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("midslip_rst_slip", out_slip, 1'b0);
    chk("midslip_rst_lock", out_block_lock, 1'b0);
    chk("midslip_rst_sh_invalid", out_sh_invalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcs_rx_block_lock.md
Name: pcs_rx_block_lock

Overview:
- Clause-49 style block-lock controller for the 10G PCS receive path, between the RX gearbox and the descrambler.
- Inspects the 2-bit sync header of each received 66-bit block and acquires block alignment by commanding gearbox bit-slips.
- Asserts lock once alignment is found; while locked, gates the descrambler's in_data_valid so unaligned data never reaches it.

Parameters:
- LOCK_COUNT, 64, consecutive valid headers needed (with zero invalid) to declare lock.
- INVALID_LIMIT, 16, invalid headers within one LOCK_COUNT window that drop lock.
- SLIP_WAIT, 4, cycles held in SLIP after an out_slip pulse so the gearbox can settle; must be >=1.
- CNT_WIDTH, 7, counter width; must hold LOCK_COUNT.

Ports:
- clk  input  1  PCS RX clock.
- rst  input  1  Asynchronous, active-low reset.
- in_header  input  2  Sync header of the current block (01 = data, 10 = control; 00/11 invalid).
- in_header_valid  input  1  in_header is qualified this cycle.
- in_data_valid  input  1  Payload valid from the gearbox.
- out_block_lock  output  1  Block alignment acquired.
- out_slip  output  1  One-cycle pulse: gearbox shifts alignment by one bit.
- out_data_valid  output  1  Equals in_data_valid AND out_block_lock (combinational); drives the descrambler in_data_valid.
- out_sh_invalid  output  1  Registered one-cycle flag: the previous qualified header was invalid (for the BER monitor).

Behaviour:
- Reset (rst=0, asynchronous): state=RESET_CNT, sh_cnt=0, inv_cnt=0, slip_timer=0, out_block_lock=0, out_slip=0, out_sh_invalid=0.
- Header valid: exactly when in_header is 01 or 10.
- Headers are evaluated only on cycles with in_header_valid=1. Counters and flags update on the following rising edge, giving 1-cycle latency from input to out_block_lock, out_slip and out_sh_invalid.

State machine:
- RESET_CNT: clear sh_cnt and inv_cnt; go to TEST_SH on the next cycle. A header qualified in this cycle is ignored.
- TEST_SH: on a qualified header, sh_cnt+=1; if invalid, also inv_cnt+=1 and out_sh_invalid=1.
- In TEST_SH, the first matching rule wins:
  - Invalid header and out_block_lock=0 -> SLIP.
  - Invalid header and inv_cnt reaches INVALID_LIMIT -> out_block_lock=0, go to SLIP.
  - sh_cnt reaches LOCK_COUNT with inv_cnt=0 -> out_block_lock=1, go to RESET_CNT.
  - sh_cnt reaches LOCK_COUNT with inv_cnt>0 (below limit) -> RESET_CNT, lock unchanged.
  - Otherwise stay in TEST_SH.
- SLIP: out_slip=1 on the entry cycle only, then hold SLIP_WAIT cycles ignoring headers, then go to RESET_CNT. out_block_lock stays 0 throughout.

Boundary cases:
- The INVALID_LIMIT-th invalid header arriving on the same header as sh_cnt=LOCK_COUNT -> the invalid-limit rule wins (go to SLIP).
- Lock is never declared from a window containing any invalid header.
- in_header_valid=0 leaves all counters frozen; the timer in SLIP still advances.
- Reset mid-slip: out_slip is deasserted immediately and lock is lost.
- out_slip is never asserted on two consecutive cycles.

Decomposition:
- Shared PCS package holds:
  - Sync header constants SH_DATA=2'b01 and SH_CTRL=2'b10.
  - State encoding {RESET_CNT, TEST_SH, SLIP}.
  - Defaults for LOCK_COUNT and INVALID_LIMIT.
- No sub-module needed; the counters and FSM live in one block.
- The top-level RX wrapper instantiates this block next to the descrambler.

Test Plan:
- 64 headers of 01 after reset -> out_block_lock rises 1 cycle after the 64th; out_slip never pulses.
- Header 00 as the first header after reset -> one out_slip pulse 1 cycle later, then no headers accepted for SLIP_WAIT=4 cycles, then counting restarts.
- Locked, then 15 invalid headers spread within a 64-header window -> lock held; window restarts; out_sh_invalid pulses 15 times.
- Locked, then 16 invalid headers within one window -> out_block_lock falls and out_slip pulses on the cycle after the 16th.
- 63 valid headers, then one invalid header -> no lock and an immediate slip; then 64 valid headers -> lock.
- Locked with in_data_valid toggling, then rst pulled low mid-stream -> out_block_lock, out_data_valid and out_slip all go 0 asynchronously.
